// File: rtl/mem_access_controller.sv
// rtl/mem_access_controller.sv - MEM-stage sequencer for a single-ported wait-state SRAM
// Optional feature macro: MEM_RD_BUF_EN (one-entry read buffer keyed on SRAM word address)
module mem_access_controller #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_AW     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_dq_out,
  input  logic [31:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  logic [SRAM_AW-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic               op_wr;
  logic               req;
  logic               hit;
  logic               last;
  logic [31:0]        offset;
  logic [SRAM_AW-1:0] word_addr;
  logic               unused_bits;

  // Byte offset from the SRAM window; the word index wraps modulo 2^SRAM_AW.
  assign offset      = address - BASE_ADDR;
  assign word_addr   = offset[SRAM_AW+1:2];
  assign unused_bits = ^{offset[31:SRAM_AW+2], offset[1:0]};

  assign req  = rd_en | wr_en;
  assign last = (cnt == LAST);

`ifdef MEM_RD_BUF_EN
  logic               buf_valid;
  logic [SRAM_AW-1:0] buf_tag;
  logic [31:0]        buf_data;

  // A pure read (write wins when both enables are high) of the buffered word skips the SRAM.
  assign hit = rd_en & ~wr_en & buf_valid & (buf_tag == word_addr);
`else
  assign hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic: DONE always returns to IDLE so a held request is seen as a new instruction.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req) state_n = hit ? DONE : ACCESS;
      ACCESS:  if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: latch the request in IDLE, count wait states, capture read data on the final cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr   <= 1'b0;
      rdata   <= '0;
`ifdef MEM_RD_BUF_EN
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= word_addr;
            wdata_q <= wdata;
            op_wr   <= wr_en;
            cnt     <= '0;
`ifdef MEM_RD_BUF_EN
            if (hit) rdata <= buf_data;
`endif
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            if (!op_wr) begin
              rdata <= sram_dq_in;
`ifdef MEM_RD_BUF_EN
              buf_valid <= 1'b1;
              buf_tag   <= addr_q;
              buf_data  <= sram_dq_in;
`endif
            end
`ifdef MEM_RD_BUF_EN
            else if (buf_valid && buf_tag == addr_q) begin
              buf_data <= wdata_q;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: strobes only during ACCESS and dropped immediately while reset is asserted.
  always_comb begin
    ready       = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_dq_out = '0;
    sram_addr   = addr_q;
    case (state)
      IDLE: ready = ~req;
      ACCESS: begin
        if (!rst) begin
          if (op_wr) begin
            sram_we_n   = 1'b0;
            sram_dq_out = wdata_q;
          end else begin
            sram_oe_n = 1'b0;
          end
        end
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule
